baccarat_fsm: RTL and testbench

Controller for the baccarat datapath. Sequences the initial four-card deal, applies the player and banker third-card rules to the live hand scores, and lights the winner(s). It sits directly upstream of the datapath on the same slow_clock: its six load strobes drive the datapath's card registers, and it consumes the datapath's `pscore`, `dscore` and `pcard3` outputs.

---
 rtl/baccarat_pkg.sv | 25 ++
 rtl/baccarat_fsm_banker_rule.sv | 27 ++
 rtl/baccarat_fsm.sv | 100 ++++++++++
 tb/tb_baccarat_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared state encoding, rule thresholds and card-rank helper for the baccarat controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL_P,
    DEAL_P3,
    EVAL_D,
    DEAL_D3,
    DONE
  } bac_state_t;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] BANKER_STAND     = 4'd7;

  // Tens and face cards count zero; rank 0 (no card) also counts zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/baccarat_fsm_banker_rule.sv
// Banker third-card rule: decides whether the banker draws, given the banker
// total and the player's third card rank. Purely combinational.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      BANKER_STAND:     draw = 1'b0;
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat hand sequencer: deals four cards, applies player/banker third-card
// rules to the datapath scores, then holds in DONE with the winner light(s).
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  bac_state_t state;
  bac_state_t next_state;
  logic       banker_draw;
  logic       natural;

  banker_rule u_banker_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  // Illegal totals of 10+ must not look like a natural.
  assign natural = ((pscore >= NATURAL_MIN) && (pscore <= 4'd9)) ||
                   ((dscore >= NATURAL_MIN) && (dscore <= 4'd9));

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state <= DEAL_P1;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DEAL_P1: next_state = DEAL_D1;
      DEAL_D1: next_state = DEAL_P2;
      DEAL_P2: next_state = DEAL_D2;
      DEAL_D2: next_state = EVAL_P;
      EVAL_P: begin
        if (natural) begin
          next_state = DONE;
        end else if (pscore < PLAYER_STAND_MIN) begin
          next_state = DEAL_P3;
        end else if ((pscore <= BANKER_STAND) && (dscore < PLAYER_STAND_MIN)) begin
          next_state = DEAL_D3;
        end else begin
          next_state = DONE;
        end
      end
      DEAL_P3: next_state = EVAL_D;
      EVAL_D:  next_state = banker_draw ? DEAL_D3 : DONE;
      DEAL_D3: next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = DEAL_P1;
    endcase
  end

  // Outputs are held low for the whole reset pulse, even though state is DEAL_P1.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    hand_done        = 1'b0;
    if (!reset) begin
      case (state)
        DEAL_P1: load_pcard1 = 1'b1;
        DEAL_D1: load_dcard1 = 1'b1;
        DEAL_P2: load_pcard2 = 1'b1;
        DEAL_D2: load_dcard2 = 1'b1;
        DEAL_P3: load_pcard3 = 1'b1;
        DEAL_D3: load_dcard3 = 1'b1;
        DONE: begin
          hand_done        = 1'b1;
          player_win_light = (pscore >= dscore);
          dealer_win_light = (dscore >= pscore);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: emulates the card datapath and checks every cycle
// against a rules-level model of a baccarat hand.
module tb_baccarat_fsm;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, hand_done;

  logic [3:0] br_dscore = 4'd0;
  logic [3:0] br_pcard3 = 4'd0;
  logic       br_draw;

  int total = 0;
  int bad = 0;

  int         pc[3];
  int         dc[3];
  logic [8:0] exp_q[$];

  baccarat_fsm dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .hand_done        (hand_done)
  );

  banker_rule u_br (
    .dscore (br_dscore),
    .pcard3 (br_pcard3),
    .draw   (br_draw)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic int val(input int rank);
    return (rank >= 10) ? 0 : rank;
  endfunction

  // Bit order: 0 p1, 1 d1, 2 p2, 3 d2, 4 p3, 5 d3, 6 done, 7 player light, 8 dealer light.
  function automatic logic [8:0] outs();
    return {dealer_win_light, player_win_light, hand_done, load_dcard3, load_pcard3,
            load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  endfunction

  function automatic logic [5:0][3:0] mk(input int p1, input int d1, input int p2,
                                          input int d2, input int p3, input int d3);
    return {4'(d3), 4'(p3), 4'(d2), 4'(p2), 4'(d1), 4'(p1)};
  endfunction

  function automatic bit model_banker(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d == 3) return v != 8;
    if (d >= 4 && d <= 6) return (v >= 2 * (d - 3)) && (v <= 7);
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic update_scores();
    pscore = 4'((val(pc[0]) + val(pc[1]) + val(pc[2])) % 10);
    dscore = 4'((val(dc[0]) + val(dc[1]) + val(dc[2])) % 10);
    pcard3 = 4'(pc[2]);
  endtask

  task automatic build_expected(input logic [5:0][3:0] c);
    int  p, d, v;
    bit  pl, dl;
    exp_q.delete();
    p = (val(int'(c[0])) + val(int'(c[2]))) % 10;
    d = (val(int'(c[1])) + val(int'(c[3]))) % 10;
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h008);
    exp_q.push_back(9'h000);
    if (p >= 8 || d >= 8) begin
    end else if (p <= 5) begin
      v = val(int'(c[4]));
      p = (p + v) % 10;
      exp_q.push_back(9'h010);
      exp_q.push_back(9'h000);
      if (model_banker(d, v)) begin
        exp_q.push_back(9'h020);
        d = (d + val(int'(c[5]))) % 10;
      end
    end else if (d <= 5) begin
      exp_q.push_back(9'h020);
      d = (d + val(int'(c[5]))) % 10;
    end
    pl = (p >= d);
    dl = (d >= p);
    for (int k = 0; k < 3; k++) exp_q.push_back({dl, pl, 7'h40});
  endtask

  // Runs one hand from reset; abort_at >= 0 asserts reset mid-cycle at that cycle index.
  task automatic run_hand(input logic [5:0][3:0] c, input string name, input int abort_at);
    logic [8:0] obs;
    reset = 1'b1;
    #1;
    check($sformatf("%s_in_reset", name), outs(), 9'h000);
    @(negedge slow_clock);
    for (int k = 0; k < 3; k++) begin
      pc[k] = 0;
      dc[k] = 0;
    end
    update_scores();
    build_expected(c);
    reset = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      obs = outs();
      check($sformatf("%s_cycle%0d", name, i + 1), obs, exp_q[i]);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check($sformatf("%s_midreset", name), outs(), 9'h000);
        return;
      end
      @(posedge slow_clock);
      #1;
      if (obs[0]) pc[0] = int'(c[0]);
      if (obs[1]) dc[0] = int'(c[1]);
      if (obs[2]) pc[1] = int'(c[2]);
      if (obs[3]) dc[1] = int'(c[3]);
      if (obs[4]) pc[2] = int'(c[4]);
      if (obs[5]) dc[2] = int'(c[5]);
      update_scores();
      @(negedge slow_clock);
    end
  endtask

  initial begin
    logic [5:0][3:0] rc;

    for (int d = 0; d < 8; d++) begin
      for (int r = 0; r < 14; r++) begin
        br_dscore = 4'(d);
        br_pcard3 = 4'(r);
        #1;
        check($sformatf("banker_d%0d_r%0d", d, r), {8'd0, br_draw},
              {8'd0, model_banker(d, val(r))});
      end
    end

    run_hand(mk(3, 1, 5, 2, 9, 9),  "natural",     -1);
    run_hand(mk(2, 3, 4, 3, 9, 9),  "tie_stand",   -1);
    run_hand(mk(1, 2, 3, 3, 7, 4),  "p_draw_b_draw", -1);
    run_hand(mk(1, 1, 3, 2, 8, 5),  "b_stand_v8",  -1);
    run_hand(mk(1, 1, 3, 2, 12, 5), "b_draw_v0",   -1);
    run_hand(mk(3, 2, 4, 2, 9, 5),  "p_stand_d_draw", -1);
    run_hand(mk(1, 2, 3, 3, 7, 4),  "abort_p3",    5);
    run_hand(mk(1, 2, 3, 3, 7, 4),  "after_abort", -1);

    for (int h = 0; h < 40; h++) begin
      for (int k = 0; k < 6; k++) rc[k] = 4'($urandom_range(13, 1));
      run_hand(rc, $sformatf("rand%0d", h), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
